mul_seq: RTL



---
 rtl/mul_seq_pkg.sv | 15 +
 rtl/mul_seq_add.sv | 25 ++
 rtl/mul_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared ALU definitions for the sequential multiplier.
//   - FSM state encodings (kept as plain 2-bit constants for legacy users)
//   - cnt_width(): bit counter width for a given operand width
package mul_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter must hold values 0..w so the iteration count always fits.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_seq_add.sv
// mul_seq_add: BUS_WIDTH-bit ripple-carry adder with carry-out.
//   a_i, b_i : addends
//   sum_o    : a_i + b_i modulo 2^BUS_WIDTH
//   cout_o   : carry out of the top bit
module mul_seq_add #(
    parameter int BUS_WIDTH = 16
) (
    input  logic [BUS_WIDTH-1:0] a_i,
    input  logic [BUS_WIDTH-1:0] b_i,
    output logic [BUS_WIDTH-1:0] sum_o,
    output logic                 cout_o
);

    logic [BUS_WIDTH:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = c[BUS_WIDTH];

endmodule

// File: rtl/mul_seq.sv
// mul_seq: sequential unsigned shift-and-add multiplier.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, a, b     : request + operands, accepted when start && in_ready
//   in_ready        : high only while idle
//   product         : registered 2*BUS_WIDTH-bit product (the accumulator)
//   out_valid       : product ready, held until out_valid && out_ready
//   out_ready       : consumer acceptance
// One multiplier bit is retired per cycle; a multiply takes BUS_WIDTH
// iterations with no early exit, so latency is data-independent.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int BUS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   a,
    input  logic [BUS_WIDTH-1:0]   b,
    output logic                   in_ready,
    output logic [2*BUS_WIDTH-1:0] product,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int CW = cnt_width(BUS_WIDTH);

    logic [1:0]             state_q, state_d;
    logic [BUS_WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*BUS_WIDTH-1:0] acc_q,   acc_d;
    logic [CW-1:0]          cnt_q,   cnt_d;

    logic [BUS_WIDTH-1:0]   add_b;
    logic [BUS_WIDTH-1:0]   add_sum;
    logic                   add_cout;

    // acc holds {partial product hi, remaining multiplier bits lo};
    // acc[0] is the multiplier bit being retired this cycle.
    assign add_b = acc_q[0] ? mcand_q : '0;

    mul_seq_add #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_add (
        .a_i    (acc_q[2*BUS_WIDTH-1:BUS_WIDTH]),
        .b_i    (add_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    acc_d   = {{BUS_WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // {carry, sum, lo} >> 1: carry-out lands in the top bit so
                // the BUS_WIDTH+1-bit intermediate is never truncated.
                acc_d = {add_cout, add_sum, acc_q[BUS_WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BUS_WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign product   = acc_q;

endmodule
